// File: rtl/serial_neg_rx.sv
// Serial two's-complement negation receiver: takes an LSB-first frame of W bits
// and presents its negation as a parallel word with a valid/ready handshake.
module serial_neg_rx #(
    parameter int W = 8
) (
    input  logic         t_clock,
    input  logic         r,
    input  logic         x,
    input  logic         x_vld,
    input  logic         start,
    output logic [W-1:0] data_out,
    output logic         valid,
    input  logic         ready,
    output logic         ovf,
    output logic         busy,
    output logic         drop
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           seen_one_reg, seen_one_next;
    logic [W-1:0]   shift_reg, shift_next;
    logic [W-1:0]   data_reg, data_next;
    logic           ovf_reg, ovf_next;
    logic           valid_reg, valid_next;
    logic           drop_reg, drop_next;
    logic           begin_frame;
    logic           rec_bit;

    // Negation passes bits through up to and including the first 1, then inverts.
    assign rec_bit = seen_one_reg ? ~x : x;

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        seen_one_next = seen_one_reg;
        shift_next    = shift_reg;
        data_next     = data_reg;
        ovf_next      = ovf_reg;
        valid_next    = valid_reg;
        drop_next     = 1'b0;
        begin_frame   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                begin_frame = x_vld && start;
            end
            SHIFT: begin
                if (x_vld) begin
                    if (start) begin
                        begin_frame = 1'b1;
                    end else if (count_reg == LAST) begin
                        data_next        = shift_reg;
                        data_next[W-1]   = rec_bit;
                        // Only 1 followed by all zeros reaches the MSB with no 1 seen yet.
                        ovf_next         = ~seen_one_reg & x;
                        valid_next       = 1'b1;
                        count_next       = '0;
                        state_next       = HOLD;
                    end else begin
                        shift_next[count_reg] = rec_bit;
                        seen_one_next         = seen_one_reg | x;
                        count_next            = count_reg + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (valid_reg && ready) begin
                    valid_next  = 1'b0;
                    state_next  = IDLE;
                    begin_frame = x_vld && start;
                end else if (x_vld && start) begin
                    drop_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (begin_frame) begin
            shift_next[0] = x;
            seen_one_next = x;
            count_next    = CW'(1);
            state_next    = SHIFT;
        end
    end

    always_ff @(posedge t_clock or negedge r) begin
        if (!r) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            seen_one_reg <= 1'b0;
            shift_reg    <= '0;
            data_reg     <= '0;
            ovf_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            drop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            seen_one_reg <= seen_one_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            ovf_reg      <= ovf_next;
            valid_reg    <= valid_next;
            drop_reg     <= drop_next;
        end
    end

    assign data_out = data_reg;
    assign valid    = valid_reg;
    assign ovf      = ovf_reg;
    assign drop     = drop_reg;
    assign busy     = (state_reg == SHIFT);

endmodule

// File: tb/tb_serial_neg_rx.sv
// Self-checking bench for serial_neg_rx (W=8): a negation model fills a
// scoreboard when frames are sent, drained on each valid/ready handshake.
module tb_serial_neg_rx;

    localparam int W = 8;

    logic         t_clock = 1'b0;
    logic         r = 1'b0;
    logic         x = 1'b0;
    logic         x_vld = 1'b0;
    logic         start = 1'b0;
    logic         ready = 1'b1;
    logic [W-1:0] data_out;
    logic         valid;
    logic         ovf;
    logic         busy;
    logic         drop;

    int n_checks = 0;
    int n_fail   = 0;
    int drop_count = 0;
    logic [W:0] exp_q[$];

    serial_neg_rx #(.W(W)) dut (
        .t_clock  (t_clock),
        .r        (r),
        .x        (x),
        .x_vld    (x_vld),
        .start    (start),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .ovf      (ovf),
        .busy     (busy),
        .drop     (drop)
    );

    always #5 t_clock = ~t_clock;

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: arithmetic negation, overflow only for the most negative value.
    function automatic logic [W:0] model(input logic [W-1:0] frame);
        logic [W-1:0] neg;
        neg = (~frame) + 1'b1;
        return {(frame == {1'b1, {(W-1){1'b0}}}), neg};
    endfunction

    // One x_vld cycle; inputs change 1 time unit after the rising edge.
    task automatic send_bit(input logic b, input logic s);
        x = b;
        start = s;
        x_vld = 1'b1;
        @(posedge t_clock);
        #1;
        x_vld = 1'b0;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge t_clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] frame, input int max_gap);
        exp_q.push_back(model(frame));
        for (int i = 0; i < W; i++) begin
            send_bit(frame[i], i == 0);
            if (i == W - 1) begin
                check_val("valid_latency", valid, 1);
                check_val("busy_after_last", busy, 0);
            end else begin
                idle($urandom_range(0, max_gap));
            end
        end
    endtask

    always @(negedge t_clock) begin
        if (r) begin
            if (drop) drop_count++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_word", {23'd0, ovf, data_out}, 32'hFFFF_FFFF);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    $display("word data_out=0x%02h ovf=%0b expected 0x%02h ovf=%0b",
                             data_out, ovf, e[W-1:0], e[W]);
                    check_val("data_out", data_out, e[W-1:0]);
                    check_val("ovf", ovf, e[W]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check_val("rst_data_out", data_out, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_drop", drop, 0);
        @(posedge t_clock);
        #1;
        r = 1'b1;
        idle(2);

        // 0xFB -> 0x05, valid for exactly one cycle
        ready = 1'b1;
        send_frame(8'hFB, 0);
        idle(1);
        check_val("valid_one_cycle", valid, 0);
        idle(2);

        // Back-to-back frames: next start coincides with the handshake
        send_frame(8'h00, 0);
        send_frame(8'h01, 0);
        send_frame(8'h80, 0);
        idle(3);

        // Hold without ready, a second start is dropped
        ready = 1'b0;
        send_frame(8'h03, 0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        idle(2);
        check_val("drop_once", drop_count, 1);
        check_val("hold_data", data_out, 8'hFD);
        check_val("hold_valid", valid, 1);
        ready = 1'b1;
        idle(1);
        check_val("released_valid", valid, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        idle(1);
        check_val("ignored_busy", busy, 0);
        check_val("ignored_valid", valid, 0);

        // Resync: restart after 4 bits
        drop_count = 0;
        for (int i = 0; i < 4; i++) send_bit(i[0], i == 0);
        check_val("partial_busy", busy, 1);
        send_frame(8'h02, 0);
        idle(3);
        check_val("resync_no_drop", drop_count, 0);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        r = 1'b0;
        #1;
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_data", data_out, 0);
        @(posedge t_clock);
        #1;
        r = 1'b1;
        idle(2);
        check_val("post_rst_valid", valid, 0);
        send_frame(8'h10, 0);
        idle(3);

        // Random gaps inside frames
        send_frame(8'h7F, 5);
        idle(2);
        send_frame(8'h81, 5);
        idle(2);
        for (int k = 0; k < 8; k++) begin
            logic [W-1:0] f;
            f = W'($urandom_range(0, 255));
            send_frame(f, 3);
            idle($urandom_range(0, 2));
        end
        idle(5);
        check_val("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_neg_rx.md
SERIAL_NEG_RX -- requirements
Module: serial_neg_rx

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the frame width in bits (W >= 2).
REQ-002 The block SHALL have port t_clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port r, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port x, input, 1, serial two's-complement data bit, LSB first.
REQ-005 The block SHALL have port x_vld, input, 1, x is sampled on this edge.
REQ-006 The block SHALL have port start, input, 1, qualified by x_vld; marks the current bit as the LSB of a new frame.
REQ-007 The block SHALL have port data_out, output, W, the recovered word, i.e. the negation of the received frame.
REQ-008 The block SHALL have port valid, output, 1, data_out and ovf hold a complete word.
REQ-009 The block SHALL have port ready, input, 1, the consumer accepts the word when valid && ready.
REQ-010 The block SHALL have port ovf, output, 1, the received frame was 1 followed by W-1 zeros (MSB first), so its negation is unrepresentable.
REQ-011 The block SHALL have port busy, output, 1, a frame is partially received.
REQ-012 The block SHALL have port drop, output, 1, one-cycle pulse when a start bit is discarded.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT and HOLD.
REQ-014 In IDLE, x_vld && start SHALL capture bit 0 and move to SHIFT with count=1. x_vld without start SHALL be ignored.
REQ-015 In SHIFT, each x_vld SHALL capture the next bit at position count, then increment count.
REQ-016 The recovered bit SHALL be x while seen_one=0 and ~x once seen_one=1. seen_one SHALL be cleared at frame start and set after any captured x=1, including the start bit.
REQ-017 When bit W-1 is captured, the block SHALL load data_out, assert valid on the next cycle (1-cycle latency), and enter HOLD. busy SHALL deassert in that same cycle.
REQ-018 ovf SHALL be 1 iff the received raw bits are exactly 1 followed by W-1 zeros (MSB first). data_out is then 1 followed by W-1 zeros.
REQ-019 In HOLD, data_out, ovf and valid SHALL stay stable until valid && ready.
REQ-020 valid && ready SHALL return the block to IDLE, deasserting valid on the next cycle.
REQ-021 If x_vld && start coincides with valid && ready, the start bit SHALL be captured and the block SHALL enter SHIFT; no frame is lost.
REQ-022 In HOLD without ready, x_vld && start SHALL pulse drop for one cycle. The bit and the rest of that frame SHALL be ignored until the next start in IDLE.
REQ-023 In SHIFT, x_vld && start SHALL abort the partial frame and restart with the current bit as bit 0 (resync). drop SHALL NOT pulse.
REQ-024 Cycles with x_vld=0 SHALL hold all state; there is no gap timeout.
REQ-025 busy SHALL be 1 exactly in SHIFT.

Reset
REQ-026 r=0 SHALL immediately force state=IDLE, count=0, seen_one=0, data_out=0, valid=0, ovf=0, busy=0, drop=0.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard the partial or held word. Nothing SHALL be emitted after release until a new start.
REQ-028 Reset release SHALL take effect synchronously to the next rising edge of t_clock.

Verification (W=8)
REQ-029 Frame 0xFB sent LSB first (bits 1,1,0,1,1,1,1,1) with start on the first bit, ready=1 -> data_out=0x05, ovf=0, valid high for 1 cycle, one cycle after the 8th bit.
REQ-030 Frames 0x00 and 0x01 -> data_out=0x00 then 0xFF, ovf=0 both. Frame 0x80 -> data_out=0x80, ovf=1.
REQ-031 Frame 0x03 with ready=0, then a second start while in HOLD -> drop pulses once, data_out stays 0xFD. Then ready=1 -> one transfer, IDLE.
REQ-032 Start on bit 4 of a frame, then 8 bits of 0x02 -> the first frame is discarded, data_out=0xFE, drop never asserts.
REQ-033 r driven low after 5 bits, released, then a full frame 0x10 -> nothing emitted for the aborted frame, then data_out=0xF0.
REQ-034 Random x_vld gaps of 0-5 cycles inside frames 0x7F and 0x81 -> data_out=0x81 and 0x7F respectively, matching a reference negation model.
